// File: rtl/chebyshev_pkg.sv
// Shared types and constants for the instruction sequencer.
// Also holds the regfile source-field positions used to decode inst_out.
package chebyshev_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int IMEM_ADDR_BITS = 6;
  localparam int ITER_BITS      = 16;

  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_MSB = 5;
  localparam int SRC2_LSB = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } seq_state_e;

  function automatic logic [4:0] src1_of(
    input logic [INST_WIDTH-1:0] w
  );
    return w[SRC1_MSB:SRC1_LSB];
  endfunction

  function automatic logic [4:0] src2_of(
    input logic [INST_WIDTH-1:0] w
  );
    return w[SRC2_MSB:SRC2_LSB];
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Program store: one write port, one registered read port.
// The read register holds its word while re_i is low.
module inst_mem #(
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port, enabled so a stalled word stays put
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sequencer.sv
// Loads a program, then replays it iter_count times, one word/cycle.
// inst_out is the RAM read register, gated to zero when not valid.
module inst_sequencer #(
  parameter int INST_WIDTH     = chebyshev_pkg::INST_WIDTH,
  parameter int IMEM_ADDR_BITS = chebyshev_pkg::IMEM_ADDR_BITS,
  parameter int ITER_BITS      = chebyshev_pkg::ITER_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [INST_WIDTH-1:0] prog_din,
  input  logic                  prog_clr,
  output logic                  prog_full,
  input  logic                  start,
  input  logic [ITER_BITS-1:0]  iter_count,
  input  logic                  abort,
  input  logic                  stall,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  inst_valid,
  output logic [ITER_BITS-1:0]  iter_idx,
  output logic                  busy,
  output logic                  done
);
  import chebyshev_pkg::*;

  localparam int AW    = IMEM_ADDR_BITS;
  localparam int LW    = IMEM_ADDR_BITS + 1;
  localparam int DEPTH = 2**IMEM_ADDR_BITS;

  seq_state_e           state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [ITER_BITS-1:0] iter_q, iter_d;
  logic [ITER_BITS-1:0] iters_q, iters_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic                  mem_we, mem_re;
  logic [AW-1:0]         mem_ra;
  logic [INST_WIDTH-1:0] mem_rd;

  logic          full, accept, last_pc, last_it;
  logic [LW-1:0] len_m1;

  assign full    = (len_q == LW'(DEPTH));
  assign len_m1  = len_q - LW'(1);
  assign last_pc = ({1'b0, pc_q} == len_m1);
  assign last_it = (iter_q == iters_q - 1'b1);
  assign accept  = valid_q & ~stall;

  inst_mem #(
    .W  (INST_WIDTH),
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we & ~rst),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (prog_din),
    .re_i    (mem_re & ~rst),
    .raddr_i (mem_ra),
    .rdata_o (mem_rd)
  );

  // Next-state, program loading and read-port control
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    iter_d  = iter_q;
    iters_d = iters_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    mem_ra  = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (prog_clr) begin
          len_d = '0;
        end else if (prog_we && !full) begin
          mem_we = 1'b1;
          len_d  = len_q + 1'b1;
        end
        if (start) begin
          if (len_q == '0 || iter_count == '0) begin
            done_d = 1'b1;
          end else begin
            iters_d = iter_count;
            pc_d    = '0;
            iter_d  = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_re  = 1'b1;
        mem_ra  = '0;
        valid_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (last_pc && last_it) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            pc_d    = '0;
            iter_d  = '0;
            state_d = S_DONE;
          end else begin
            if (last_pc) begin
              pc_d   = '0;
              iter_d = iter_q + 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
            mem_re = 1'b1;
            mem_ra = pc_d;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      pc_d    = '0;
      iter_d  = '0;
      mem_re  = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      iter_q  <= '0;
      iters_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      iter_q  <= iter_d;
      iters_q <= iters_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign inst_out   = valid_q ? mem_rd : '0;
  assign inst_valid = valid_q;
  assign iter_idx   = iter_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign prog_full  = full;

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
Instruction fetch/issue stage that sits directly upstream of the register file and datapath. It is loaded once with a program over a simple write port. On start, it replays that program for a programmable number of iterations, presenting one instruction per cycle on inst_out. The register file decodes its source addresses from inst_out; a stall input from downstream freezes issue.

Parameters:
INST_WIDTH, 32, instruction word width (matches regfile inst input)
IMEM_ADDR_BITS, 6, instruction memory address width; depth = 2**IMEM_ADDR_BITS
ITER_BITS, 16, width of iteration counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
prog_we  input  1  write prog_din to next imem location (IDLE only)
prog_din  input  INST_WIDTH  instruction word to load
prog_clr  input  1  reset load pointer/program length to 0 (IDLE only)
prog_full  output  1  load pointer == depth; further writes ignored
start  input  1  begin execution (sampled in IDLE only)
iter_count  input  ITER_BITS  number of program passes, sampled on start
abort  input  1  terminate run, return to IDLE without done
stall  input  1  downstream not ready; hold current instruction
inst_out  output  INST_WIDTH  issued instruction
inst_valid  output  1  inst_out holds a live instruction
iter_idx  output  ITER_BITS  zero-based pass number of inst_out
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after last instruction accepted

Behaviour:
- Reset: state IDLE; wr_ptr, prog_len, pc, iter counters = 0; inst_out = 0; inst_valid, busy, done, prog_full = 0. imem contents are not cleared.
- States: IDLE, FILL, RUN, DONE.
- IDLE: prog_we writes imem[wr_ptr] and increments wr_ptr; prog_len = wr_ptr. Writes at wr_ptr == depth are ignored and prog_full = 1. prog_clr has priority over prog_we in the same cycle. prog_we/prog_clr are ignored outside IDLE.
- start in IDLE:
  - If prog_len == 0 or iter_count == 0, pulse done in the next cycle and stay IDLE.
  - Otherwise latch iter_count, pc = 0, go to FILL.
- FILL (1 cycle): issues the memory read of address 0 (synchronous read, 1-cycle latency), then goes to RUN. The first inst_valid is high on the 2nd rising edge after the start edge.
- RUN: an instruction is accepted when inst_valid & !stall.
  - On acceptance, the next instruction is loaded into inst_out on that edge.
  - pc increments; at pc == prog_len-1 it wraps to 0 and iter_idx increments.
  - With stall high: pc, the memory read address, inst_out, inst_valid and iter_idx are all held. The memory read must be re-issued or output-enabled so no word is lost or duplicated.
  - Sustained throughput is 1 instruction/cycle with stall low.
- Last instruction: the pair (pc == prog_len-1, iter_idx == latched_iter-1). When it is accepted, go to DONE; inst_valid = 0 and inst_out = 0 on that edge.
- DONE (1 cycle): done = 1, busy = 1; next state is IDLE.
- abort: has priority over everything except rst. From FILL/RUN/DONE, go to IDLE next edge with inst_valid = 0 and no done pulse. A done already asserted in that cycle completes.
- start outside IDLE is ignored.
- iter_count changes after start have no effect.
- rst mid-run behaves identically to power-on reset.
- prog_len == 1: the same word is issued every cycle, iter_idx increments every accepted cycle.
- Width rules:
  - pc and wr_ptr are IMEM_ADDR_BITS wide.
  - prog_len is IMEM_ADDR_BITS+1 wide so that a full memory is representable.
  - The iteration compare uses ITER_BITS and has no overflow (max iter_count = 2**ITER_BITS-1).

Decomposition:
- Shared package chebyshev_pkg: INST_WIDTH, state enum (IDLE/FILL/RUN/DONE), field positions of src1/src2 address fields (bits 10:6, 5:1) for bench decoding.
- Sub-module inst_mem: simple dual-port RAM with one write port, one synchronous read port with read-enable, depth 2**IMEM_ADDR_BITS, maps to block RAM.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44, start with iter_count=2, stall=0 -> inst_valid on 2nd edge after start. inst_out sequence is 11,22,33,44,11,22,33,44 and iter_idx is 0,0,0,0,1,1,1,1. done pulses exactly once, 1 cycle after the final 0x44 is accepted; busy falls with it.
- Same program, stall high for 3 cycles while inst_out=0x22 -> 0x22 is held 4 cycles total, then 0x33 follows; no word is skipped or repeated.
- start with prog_len=0, or with iter_count=0 -> done pulses the next cycle, inst_valid never rises, busy stays 0.
- Write depth+2 words -> prog_full=1 after `depth` writes, prog_len=depth, the extra writes leave imem unchanged. prog_clr followed by 1 write -> prog_len=1, prog_full=0.
- During a run, assert abort while inst_out=0x33 -> next edge: inst_valid=0, busy=0, no done. A subsequent start replays the program from 0x11.
- Assert rst mid-run with prog_we=1 -> all outputs 0 and state IDLE. prog_len=0, so a following start produces an immediate done.
